// File: rtl/rca2_pkg.sv
// Shared definitions for the rca2 self-test loop: state encodings, default
// sizes, full-adder golden model and MISR feedback polynomial.
package rca2_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NVEC  = 8;

    // Analyzer FSM encodings
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EVAL    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // x^8 + x^6 + x^5 + x^4 + 1, x^8 implicit (Galois form)
    localparam logic [7:0] MISR_POLY = 8'b0111_0001;

    function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/rca2_misr.sv
// Multiple-input signature register: Galois LFSR folding in one data word per
// enabled cycle. Only instantiated when RCA2_RESP_MISR_EN is defined.
module rca2_misr #(
    parameter int         W    = 8,
    parameter logic [W-1:0] POLY = W'(8'b0111_0001)
) (
    input  logic         clk,
    input  logic         init,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (init || clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= ({sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0)) ^ data;
        end
    end

endmodule

// File: rtl/rca2_resp_analyzer.sv
// Response analyzer for the 4-bit ripple-carry adder self-test loop.
// Optional signature compaction is enabled by defining RCA2_RESP_MISR_EN.
module rca2_resp_analyzer
    import rca2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NVEC  = DEF_NVEC,
    parameter int CNT_W = 3
) (
    input  logic                         clk,
    input  logic                         init,
    input  logic                         test,
    input  logic                         vec_valid,
    input  logic [CNT_W-1:0]             count,
    input  logic [WIDTH-1:0]             at,
    input  logic [WIDTH-1:0]             bt,
    input  logic                         cint,
    input  logic [WIDTH-1:0]             adder_sums,
    input  logic [WIDTH-1:0]             adder_carrys,
`ifdef RCA2_RESP_MISR_EN
    input  logic [2*WIDTH-1:0]           golden_sig,
    output logic [2*WIDTH-1:0]           sig,
    output logic                         sig_fail,
`endif
    output logic [WIDTH-1:0]             fault_map,
    output logic [$clog2(WIDTH+1)-1:0]   fault_cnt,
    output logic                         single_fault,
    output logic                         double_fault,
    output logic                         uncorrectable,
    output logic                         seq_err,
    output logic                         busy,
    output logic                         done
);

    localparam int FC_W = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NVEC-1);

    logic [1:0]       state;
    logic [CNT_W-1:0] exp_idx;
    logic [WIDTH-1:0] mis;
    logic [1:0]       g;
    logic [FC_W-1:0]  pop;

    // Each cell is isolated in test mode, so every cell sees cint as carry-in
    always_comb begin
        mis = '0;
        g   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            g      = fa_golden(at[i], bt[i], cint);
            mis[i] = (adder_sums[i] != g[0]) | (adder_carrys[i] != g[1]);
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + FC_W'(fault_map[i]);
        end
    end

    assign busy = (state == S_COLLECT) || (state == S_EVAL);

`ifdef RCA2_RESP_MISR_EN
    rca2_misr #(
        .W    (2*WIDTH),
        .POLY ((2*WIDTH)'(MISR_POLY))
    ) u_misr (
        .clk   (clk),
        .init  (init),
        .clear (state == S_IDLE && test),
        .en    (state == S_COLLECT && test && vec_valid),
        .data  ({adder_carrys, adder_sums}),
        .sig   (sig)
    );
`endif

    always_ff @(posedge clk) begin
        if (init) begin
            state         <= S_IDLE;
            exp_idx       <= '0;
            fault_map     <= '0;
            fault_cnt     <= '0;
            single_fault  <= 1'b0;
            double_fault  <= 1'b0;
            uncorrectable <= 1'b0;
            seq_err       <= 1'b0;
            done          <= 1'b0;
`ifdef RCA2_RESP_MISR_EN
            sig_fail      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (test) begin
                        state         <= S_COLLECT;
                        exp_idx       <= '0;
                        fault_map     <= '0;
                        fault_cnt     <= '0;
                        single_fault  <= 1'b0;
                        double_fault  <= 1'b0;
                        uncorrectable <= 1'b0;
                        seq_err       <= 1'b0;
                        done          <= 1'b0;
`ifdef RCA2_RESP_MISR_EN
                        sig_fail      <= 1'b0;
`endif
                    end
                end
                S_COLLECT, S_EVAL: begin
                    if (!test) begin
                        // Abort drops partial results but keeps seq_err for diagnosis
                        state         <= S_IDLE;
                        fault_map     <= '0;
                        single_fault  <= 1'b0;
                        double_fault  <= 1'b0;
                        uncorrectable <= 1'b0;
                        done          <= 1'b0;
`ifdef RCA2_RESP_MISR_EN
                        sig_fail      <= 1'b0;
`endif
                    end else if (state == S_COLLECT) begin
                        if (vec_valid) begin
                            fault_map <= fault_map | mis;
                            exp_idx   <= exp_idx + 1'b1;
                            if (count != exp_idx) begin
                                seq_err <= 1'b1;
                            end
                            if (count == LAST_IDX || exp_idx == LAST_IDX) begin
                                state <= S_EVAL;
                            end
                        end
                    end else begin
                        fault_cnt     <= pop;
                        single_fault  <= (pop == FC_W'(1));
                        double_fault  <= (pop == FC_W'(2));
                        uncorrectable <= (pop >  FC_W'(2));
`ifdef RCA2_RESP_MISR_EN
                        sig_fail      <= (sig != golden_sig);
`endif
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!test) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rca2_resp_analyzer.md
Name: rca2_resp_analyzer

Overview:
Output response analyzer for the 4-bit ripple-carry adder self-test loop. It is the receive end of the test-pattern path driven by rca2_tpg. It samples per-cell sum and carry outputs of the adder under test for each applied vector and compares them with internally computed golden values. It accumulates a per-cell fault map and classifies the result as none, single, double or uncorrectable, for use by the mux-select generator.

Parameters:
- WIDTH, 4, number of full-adder cells in the adder under test.
- NVEC, 8, number of test vectors per session.
- CNT_W, 3, width of the vector index; must satisfy 2**CNT_W >= NVEC.

Ports:
- clk  input  1  system clock
- init  input  1  synchronous active-high reset
- test  input  1  test-session enable from the controller
- vec_valid  input  1  current vector and responses are valid this cycle
- count  input  CNT_W  vector index from the TPG
- at  input  WIDTH  applied A operand
- bt  input  WIDTH  applied B operand
- cint  input  1  applied carry-in; in test mode every cell is isolated and sees cint
- adder_sums  input  WIDTH  per-cell sum outputs under test
- adder_carrys  input  WIDTH  per-cell carry outputs under test
- fault_map  output  WIDTH  bit i=1 means cell i failed at least once
- fault_cnt  output  $clog2(WIDTH+1)  population count of fault_map
- single_fault, double_fault, uncorrectable  output  1 each  classification flags, one-hot or all zero
- seq_err  output  1  sticky: out-of-order vector index
- busy  output  1  session in progress
- done  output  1  result valid

Behaviour:
- All state updates on posedge clk. init=1 forces IDLE, and all outputs and accumulators go to 0. init has priority over every other input.
- Golden per cell i: gs_i = at[i]^bt[i]^cint, gc_i = majority(at[i], bt[i], cint). mis_i = (adder_sums[i]!=gs_i) | (adder_carrys[i]!=gc_i).
- IDLE: busy=0. When test=1, go to COLLECT and clear fault_map, fault_cnt, flags, seq_err, done and the expected-index counter exp_idx.
- COLLECT: busy=1. On each vec_valid cycle:
  - fault_map <= fault_map | mis, visible the next cycle.
  - If count != exp_idx, set seq_err (sticky); exp_idx still increments.
  - If count == NVEC-1, or exp_idx == NVEC-1, go to EVAL after this vector is absorbed.
  - Cycles without vec_valid are ignored; there is no timeout.
- EVAL: one cycle.
  - fault_cnt <= popcount(fault_map).
  - single_fault <= (cnt==1), double_fault <= (cnt==2), uncorrectable <= (cnt>2).
  - Go to DONE.
- DONE: done=1 and busy=0. Results hold until test falls; then return to IDLE with results still held. A new rising session clears them.
- test falling in COLLECT or EVAL aborts to IDLE. fault_map, flags and done go to 0, and seq_err holds.
- Latency: done rises 2 cycles after the last vec_valid.
- vec_valid while in IDLE or DONE is ignored.
- WIDTH=4 and NVEC=8 gives a 3-bit exp_idx that wraps naturally. Termination uses the compare, not overflow.

Optional Feature:
- Macro RCA2_RESP_MISR_EN.
- When defined: adds output sig[2*WIDTH-1:0] and input golden_sig[2*WIDTH-1:0].
  - sig is an internal MISR, reset to 0 at session start, that absorbs {adder_carrys, adder_sums} on every COLLECT vec_valid.
  - Polynomial for 8 bits: x^8+x^6+x^5+x^4+1.
  - Adds sig_fail output = (sig != golden_sig), registered in EVAL.
- When undefined: no sig, golden_sig or sig_fail ports, and no MISR logic.

Decomposition:
- Shared package rca2_pkg holds:
  - the state enum (IDLE, COLLECT, EVAL, DONE)
  - default NVEC and WIDTH constants
  - a function fa_golden(a, b, c) returning {carry, sum}
  - the MISR polynomial constant
- One sub-module, rca2_misr, is instantiated only under RCA2_RESP_MISR_EN.

Test Plan:
- Fault-free: apply 8 vectors with count 0..7 and matching outputs. Expect fault_map=0000, fault_cnt=0, all flags 0, done=1 two cycles after vector 7, seq_err=0.
- Single fault: force adder_sums[2]=0 on at=0100, bt=0000, cint=0 (count 3). Expect fault_map=0100, fault_cnt=1, single_fault=1.
- Double fault: force adder_carrys[1]=1 and adder_sums[3] inverted across all vectors. Expect fault_map=1010, fault_cnt=2, double_fault=1.
- Triple fault: corrupt cells 0, 1 and 3. Expect fault_map=1011, uncorrectable=1, single_fault=0, double_fault=0.
- Abort: drop test after count 4. Expect busy=0, done=0, fault_map=0 next cycle. A new session then completes normally.
- Sequence error: send count 0,1,3,4,5,6,7 (7 vectors). Expect seq_err=1, done=1 after count 7, and seq_err still 1 in DONE.
